// File: rtl/matrix_mult_master_pkg.sv
// Shared types and constants for the matrix multiply memory master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_mult_master_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int MAX_N  = 8;
    localparam int IDX_W  = $clog2(MAX_N);

    localparam logic [ADDR_W-1:0] A_BASE_DEF = 17'd0;
    localparam logic [ADDR_W-1:0] B_BASE_DEF = 17'd64;
    localparam logic [ADDR_W-1:0] C_BASE_DEF = 17'd128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_C = 3'd3,
        DONE = 3'd4
    } state_e;

    // Row-major word address of element [row][col] in a dim x dim matrix at base.
    function automatic logic [ADDR_W-1:0] mm_addr(
        input logic [ADDR_W-1:0] base,
        input logic [IDX_W-1:0]  row,
        input logic [IDX_W-1:0]  col,
        input logic [ADDR_W-1:0] dim
    );
        return base + ADDR_W'(row) * dim + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate datapath: holds the A operand and the running dot product.
// Latency: a_reg and acc update on the clock edge after ld_a_i / en_i.
// Backpressure: none; clr_i takes priority over en_i.
module mm_mac
    import matrix_mult_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              ld_a_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] acc_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] prod;

    // Next operand and accumulator; product keeps only the low word (mod 2^32).
    always_comb begin
        prod  = a_q * rdata_i;
        a_d   = a_q;
        acc_d = acc_q;
        if (ld_a_i) begin
            a_d = rdata_i;
        end
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mult_master.sv
// Reads A and B row-major from memory, computes C = A x B, writes C back.
// Latency: 2N+1 cycles per element; done in cycle t0+1+N*N*(2N+1) after start at t0.
// Backpressure: none; memory answers combinationally, start ignored unless IDLE.
module matrix_mult_master
    import matrix_mult_master_pkg::*;
#(
    parameter int unsigned       N      = 3,
    parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
    parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
    parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [IDX_W-1:0]  LAST = IDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] DIM  = ADDR_W'(N);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] i_d;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] j_d;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] k_d;

    logic              mac_clr;
    logic              mac_ld_a;
    logic              mac_en;
    logic [DATA_W-1:0] acc;

    mm_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mac_clr),
        .ld_a_i  (mac_ld_a),
        .en_i    (mac_en),
        .rdata_i (mem_rdata),
        .acc_o   (acc)
    );

    // State and loop index registers; reset drops every output at once since
    // outputs decode purely from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Next state, index stepping, MAC control and state-decoded bus outputs.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        mac_clr   = 1'b0;
        mac_ld_a  = 1'b0;
        mac_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        address   = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_A;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            RD_A: begin
                busy     = 1'b1;
                memread  = 1'b1;
                address  = mm_addr(A_BASE, i_q, k_q, DIM);
                mac_ld_a = 1'b1;
                state_d  = RD_B;
            end
            RD_B: begin
                busy    = 1'b1;
                memread = 1'b1;
                address = mm_addr(B_BASE, k_q, j_q, DIM);
                mac_en  = 1'b1;
                if (k_q == LAST) begin
                    state_d = WR_C;
                end else begin
                    k_d     = k_q + IDX_W'(1);
                    state_d = RD_A;
                end
            end
            WR_C: begin
                busy      = 1'b1;
                memwrite  = 1'b1;
                address   = mm_addr(C_BASE, i_q, j_q, DIM);
                mem_wdata = acc;
                k_d       = '0;
                mac_clr   = 1'b1;
                if (j_q != LAST) begin
                    j_d     = j_q + IDX_W'(1);
                    state_d = RD_A;
                end else if (i_q != LAST) begin
                    j_d     = '0;
                    i_d     = i_q + IDX_W'(1);
                    state_d = RD_A;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_mult_master.sv
// Randomized self-checking bench for matrix_mult_master against a dot-product model.
// Latency: checks done timing, bus order and written results per run.
// Backpressure: bench memory answers reads combinationally.
module tb_matrix_mult_master;

    localparam int N      = 3;
    localparam int A_B    = 0;
    localparam int B_B    = 64;
    localparam int C_B    = 128;
    localparam int OPS    = N * N * (2 * N + 1);
    localparam int LIM    = OPS + 6;
    localparam logic [31:0] SENT = 32'h5A5A_5A5A;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        bsy;
        logic        dn;
        logic [16:0] addr;
        logic [31:0] wd;
    } bus_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        memread;
    logic        memwrite;
    logic [16:0] address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:(1<<17)-1];
    bus_t        tr [$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    matrix_mult_master #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .memread   (memread),
        .memwrite  (memwrite),
        .address   (address),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = memread ? mem[address] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < N * N; e++) begin
            mem[A_B + e] = $urandom;
            mem[B_B + e] = $urandom;
        end
    endtask

    task automatic clear_c();
        for (int e = 0; e < N * N; e++) mem[C_B + e] = SENT;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One full multiply: model C, predict the bus trace, run, then compare.
    task automatic run_check(input string tag, input bit poke);
        logic [31:0] exp_c [N*N];
        bus_t        exp_q [$];
        bus_t        b;
        logic [31:0] sum;
        int          bad, both, ndone, dcyc, nbusy;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 32'd0;
                for (int k = 0; k < N; k++) begin
                    sum = sum + mem[A_B + i*N + k] * mem[B_B + k*N + j];
                    b = '0; b.rd = 1'b1; b.addr = 17'(A_B + i*N + k); exp_q.push_back(b);
                    b = '0; b.rd = 1'b1; b.addr = 17'(B_B + k*N + j); exp_q.push_back(b);
                end
                exp_c[i*N + j] = sum;
                b = '0; b.wr = 1'b1; b.addr = 17'(C_B + i*N + j); b.wd = sum; exp_q.push_back(b);
            end
        end
        while (exp_q.size() < LIM) exp_q.push_back('0);
        clear_c();
        tr.delete();
        pulse_start();
        for (int c = 0; c < LIM; c++) begin
            if (c > 0) @(negedge clk);
            b.rd = memread; b.wr = memwrite; b.bsy = busy; b.dn = done;
            b.addr = address; b.wd = mem_wdata;
            tr.push_back(b);
            if (memwrite) mem[address] = mem_wdata;
            start = poke && (c == 9 || done);
        end
        start = 1'b0;
        bad = 0; both = 0; ndone = 0; dcyc = -1; nbusy = 0;
        for (int c = 0; c < LIM; c++) begin
            if (tr[c].rd !== exp_q[c].rd || tr[c].wr !== exp_q[c].wr ||
                tr[c].addr !== exp_q[c].addr || tr[c].wd !== exp_q[c].wd) bad++;
            if (tr[c].rd && tr[c].wr) both++;
            if (tr[c].dn) begin ndone++; dcyc = c; end
            if (tr[c].bsy) nbusy++;
        end
        chk({tag, "_busseq_bad"}, 64'(bad), 0);
        chk({tag, "_rd_wr_overlap"}, 64'(both), 0);
        chk({tag, "_done_count"}, 64'(ndone), 1);
        chk({tag, "_done_cycle"}, 64'(dcyc), 64'(OPS));
        chk({tag, "_busy_first"}, 64'(tr[0].bsy), 1);
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(OPS + 1));
        chk({tag, "_busy_after"}, 64'(tr[OPS+1].bsy), 0);
        for (int e = 0; e < N * N; e++)
            chk($sformatf("%s_c%0d", tag, e), 64'(mem[C_B + e]), 64'(exp_c[e]));
    endtask

    initial begin
        int          basic_addr [7] = '{0, 64, 1, 67, 2, 70, 128};
        logic [31:0] basic_c [9]    = '{4, 2, 4, 10, 5, 10, 16, 8, 16};
        logic [31:0] bpat [9]       = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        int          nwr;
        bit          hit;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_strobes", 64'({memread, memwrite}), 0);
        chk("rst_address", 64'(address), 0);
        chk("rst_wdata", 64'(mem_wdata), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Basic multiply with the reference pattern.
        for (int e = 0; e < 9; e++) begin
            mem[A_B + e] = 32'(e + 1);
            mem[B_B + e] = bpat[e];
        end
        run_check("basic", 1'b0);
        for (int c = 0; c < 7; c++)
            chk($sformatf("basic_addr%0d", c), 64'(tr[c].addr), 64'(basic_addr[c]));
        chk("basic_first_wdata", 64'(tr[6].wd), 4);
        for (int e = 0; e < 9; e++)
            chk($sformatf("basic_const_c%0d", e), 64'(mem[C_B + e]), 64'(basic_c[e]));

        // Accumulator wraps modulo 2^32.
        for (int e = 0; e < 9; e++) begin
            mem[A_B + e] = 32'd0;
            mem[B_B + e] = 32'd0;
        end
        mem[A_B] = 32'hFFFF_FFFF;
        mem[B_B] = 32'd2;
        run_check("wrap", 1'b0);
        chk("wrap_c00", 64'(mem[C_B]), 64'h0000_0000_FFFF_FFFE);

        // Random operands, one run also pokes start while busy and on done.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_check($sformatf("rand%0d", r), r == 1);
        end

        // Asynchronous reset in the middle of the third result write.
        fill_random();
        clear_c();
        pulse_start();
        nwr = 0;
        hit = 1'b0;
        for (int c = 0; c < LIM && !hit; c++) begin
            if (memwrite) begin
                nwr++;
                if (nwr == 3) hit = 1'b1;
            end
            if (!hit) @(negedge clk);
        end
        chk("midrst_third_write_seen", 64'(hit), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_memwrite", 64'(memwrite), 0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_bus", 64'({memread, address, mem_wdata}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_check("rerun", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_mult_master.md
Name: matrix_mult_master

Overview:
- Memory-side initiator that drives the main-memory port (memread, memwrite, address, write data) and consumes the memory's read data.
- Reads two N x N operand matrices, stored row-major, from main memory and computes C = A x B.
- Writes each result element back to the output-matrix region.
- Sits between the top-level control/testbench (start/done) and the main memory; it is the only requester on that port while busy.

Parameters:
- N, 3, matrix dimension (legal range 1..8).
- A_BASE, 17'd0, word address of matrix A element [0][0].
- B_BASE, 17'd64, word address of matrix B element [0][0].
- C_BASE, 17'd128, word address of result element [0][0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a multiply; sampled in IDLE only.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when the last element of C has been written.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- address  output  17  word address to memory.
- mem_wdata  output  32  data to memory (memory data_in).
- mem_rdata  input  32  data from memory (memory data_out); combinational w.r.t. address/memread.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; i, j, k, acc, a_reg cleared.
  - All outputs 0: busy, done, memread, memwrite, address, mem_wdata.
- Reset mid-operation: identical to the above, effective immediately. Any in-flight write is abandoned; memwrite drops without waiting for clk.
- States:
  - IDLE: start=1 -> RD_A, with i=j=k=0 and acc=0. Otherwise stay.
  - RD_A: memread=1, address=A_BASE+i*N+k. At the clock edge, a_reg<=mem_rdata -> RD_B.
  - RD_B: memread=1, address=B_BASE+k*N+j. At the edge, acc<=acc+a_reg*mem_rdata.
    - If k==N-1 -> WR_C.
    - Else k<=k+1 -> RD_A.
  - WR_C: memwrite=1, address=C_BASE+i*N+j, mem_wdata=acc (final, includes the last product). At the edge, k<=0, acc<=0, then:
    - j<N-1: j<=j+1 -> RD_A.
    - j==N-1, i<N-1: j<=0, i<=i+1 -> RD_A.
    - j==N-1, i==N-1 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Outputs are registered and state-decoded. memread and memwrite are never high in the same cycle.
- In IDLE and DONE: address=0, mem_wdata=0, memread=memwrite=0.
- Latency:
  - start sampled at edge t0; first RD_A cycle is t0+1.
  - Each result element takes 2N+1 cycles.
  - done is asserted in cycle t0+1+N*N*(2N+1); for N=3 that is t0+64.
- Arithmetic:
  - Unsigned 32x32 multiply truncated to low 32 bits.
  - Accumulate modulo 2^32; no overflow flag.
- Address: computed in 17 bits; offsets i*N+k < N*N never overflow for legal N.
- start while busy is ignored: no restart and no queuing. start asserted in the same cycle as done is also ignored; a new start is accepted the cycle after returning to IDLE.
- mem_rdata is ignored in WR_C, IDLE and DONE.

Decomposition:
- Shared include/package holds:
  - State encoding constants: IDLE=3'd0, RD_A=3'd1, RD_B=3'd2, WR_C=3'd3, DONE=3'd4.
  - Memory map constants: A_BASE/B_BASE/C_BASE defaults, ADDR_W=17, DATA_W=32.
- One natural sub-module: mm_mac (a_reg x rdata + acc, with clear and enable). FSM and index counters stay in matrix_mult_master.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0 and state IDLE. Assert rst_n low asynchronously between clk edges -> outputs clear before the next edge.
- Basic multiply:
  - Stimulus: A=[1..9] at 0..8, B=[1,0,1,0,1,0,1,0,1] at 64..72, start pulse.
  - Response: writes to 128..136 of 4,2,4,10,5,10,16,8,16 in that order; done exactly at t0+64; busy high t0+1..t0+64.
- Bus sequence check:
  - First 7 cycles after start: addresses 0(rd), 64(rd), 1(rd), 67(rd), 2(rd), 70(rd), 128(wr, data 4).
  - memread/memwrite never both 1.
- Wrap-around: A[0][0]=32'hFFFFFFFF, B[0][0]=2, all other entries 0 -> C[0][0]=32'hFFFFFFFE, all other C entries 0.
- start while busy: pulse start at t0+10 and at the done cycle -> no change to the address sequence; single done; returns to IDLE.
- Reset mid-operation: rst_n=0 during the 3rd WR_C -> memwrite drops immediately. After release plus a new start, the full correct result is rewritten and done fires at the new t0+64.
